shift_register_n: RTL
=====================

# shift_register_n

Parametrised universal register built on the team's D flip-flop cell: WIDTH bits with async reset, complementary outputs (q / q_n), hold / parallel load / shift-left / shift-right each cycle, and a counted burst-shift mode driven by a small state machine with busy/done handshake. It is the multi-bit successor to the single-bit D flip-flop and feeds serialisers, barrel-rotate helpers and scan-style test chains in the memory library.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2
- RESET_VALUE, 0 (WIDTH bits), value loaded into q on reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; all state returns to reset values immediately
- d  input  WIDTH  parallel load data
- mode  input  2  00 hold, 01 load, 10 shift left, 11 shift right
- rotate  input  1  1: shifted-out bit re-enters at the opposite end; 0: sin enters
- sin  input  1  serial input
- start  input  1  request burst shift of `count` positions using `mode`/`rotate`
- count  input  $clog2(WIDTH+1)  burst length, 0..WIDTH
- q  output  WIDTH  register contents
- q_n  output  WIDTH  bitwise complement of q, always ~q
- sout  output  1  last bit shifted out, registered
- busy  output  1  high while burst in progress
- done  output  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=0: per edge apply mode. Hold: q unchanged. Load: q←d. Left: q←{q[W-2:0], fill}, fill = rotate ? q[W-1] : sin, sout←q[W-1]. Right: q←{fill, q[W-1:1]}, fill = rotate ? q[0] : sin, sout←q[0].
- IDLE, start=1: latch mode, rotate, count; q not modified at this edge. If latched mode ∈ {10,11} and count>0 → SHIFT, else → DONE.
- SHIFT: one shift per edge with latched mode/rotate; sin sampled live each edge. Remaining counter decrements; at edge performing final shift → DONE. mode, start, count, d ignored.
- DONE: one cycle, done=1; → IDLE unconditionally; start ignored in DONE.
- sout only updates on a shift; hold/load leave it unchanged.
- Rotate by WIDTH positions returns original q.

## Timing
- Reset values: q=RESET_VALUE, q_n=~RESET_VALUE, sout=0, busy=0, done=0, state IDLE.
- Reset asserted mid-burst aborts it; no done pulse.
- start sampled at edge k, count=N>0, shift mode: shifts at edges k+1..k+N; busy=1 from after edge k through edge k+N; done=1 for cycle after edge k+N; IDLE after edge k+N+1.
- count=0 or non-shift mode with start: done=1 in cycle after edge k, q unchanged, busy never asserted.
- busy and done never high together.
- q_n combinational from q; zero latency.

## Structure
- Package shift_reg_pkg: mode constants MODE_HOLD/MODE_LOAD/MODE_SHL/MODE_SHR, state enum (IDLE, SHIFT, DONE).
- Sub-module dff_r: one-bit D flip-flop with async active-high reset to a parameter value, outputs q and q_n; WIDTH instances generated for the data path. FSM, counter and next-value mux live in shift_register_n.

## Test plan
- Reset with RESET_VALUE=8'hA5, then release → q=A5, q_n=5A, busy=0, done=0, sout=0; hold 3 cycles, q stays A5.
- Load d=8'h81; mode=10, rotate=0, sin=1 for one edge → q=03, sout=1; mode=11, rotate=1 one edge → q=81, sout=1.
- q=8'h01, start with mode=10, rotate=1, count=3 → busy 3 cycles, q=02,04,08, done one cycle, busy=0 during done.
- q=8'h3C, start with count=8, rotate=1, mode=11 → after burst q=3C; start with count=0 → done next cycle, q unchanged, busy never high.
- Mid-burst (count=6, after 2 shifts) assert reset → q=RESET_VALUE immediately, busy=0, no done pulse; start toggled during SHIFT/DONE has no effect.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared constants for shift_register_n: operating modes and burst FSM states.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Both shift modes share the upper mode bit.
  function automatic logic is_shift_mode(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/dff_r.sv
// One-bit D flip-flop with asynchronous active-high reset to RESET_VAL.
// Provides true and complementary outputs; one-cycle latency, no backpressure.
module dff_r #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_n
);

  logic bit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bit_q <= RESET_VAL;
    else       bit_q <= d;
  end

  assign q   = bit_q;
  assign q_n = ~bit_q;

endmodule

// File: rtl/shift_register_n.sv
// Universal WIDTH-bit register: hold / load / shift left / shift right, plus a counted
// burst shift (IDLE -> SHIFT -> DONE) with busy/done handshake. One edge per operation.
module shift_register_n
  import shift_reg_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  localparam int               CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             sin,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             rot_q, rot_d;
  logic             sout_q, sout_d;
  logic [WIDTH-1:0] q_d;

  logic             do_shift;
  logic [1:0]       op_mode;
  logic             op_rot;
  logic             fill;

  // Data path: one reset-valued flop per bit so each bit carries its own reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_r #(
      .RESET_VAL (RESET_VALUE[i])
    ) u_dff (
      .clk   (clk),
      .reset (reset),
      .d     (q_d[i]),
      .q     (q[i]),
      .q_n   (q_n[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    rot_d    = rot_q;
    sout_d   = sout_q;
    q_d      = q;
    do_shift = 1'b0;
    op_mode  = mode;
    op_rot   = rotate;
    fill     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          rot_d   = rotate;
          cnt_d   = count;
          state_d = (is_shift_mode(mode) && (count != '0)) ? SHIFT : DONE;
        end else begin
          case (mode)
            MODE_LOAD: q_d      = d;
            MODE_SHL:  do_shift = 1'b1;
            MODE_SHR:  do_shift = 1'b1;
            default:   q_d      = q;
          endcase
        end
      end
      SHIFT: begin
        // Burst uses the mode/rotate captured at start; sin stays live.
        op_mode  = mode_q;
        op_rot   = rot_q;
        do_shift = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_shift) begin
      if (op_mode == MODE_SHR) begin
        fill   = op_rot ? q[0] : sin;
        q_d    = {fill, q[WIDTH-1:1]};
        sout_d = q[0];
      end else begin
        fill   = op_rot ? q[WIDTH-1] : sin;
        q_d    = {q[WIDTH-2:0], fill};
        sout_d = q[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      rot_q   <= 1'b0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      rot_q   <= rot_d;
      sout_q  <= sout_d;
    end
  end

  assign sout = sout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule
